if_issue: RTL and testbench
===========================

// Module: if_issue
// PURPOSE
//  Instruction fetch/issue front end that drives the id/ex/wb pipe's instruction
//  inputs (opcode, Rs1, Rs2, Rd, imm, start). It walks a PC through a synchronous
//  instruction memory and decodes each 32-bit word. It inserts bubbles on RAW
//  hazards or external stall, and stops on a HALT word.
// PARAMETERS
//  AW        8   instruction memory address width (PC width)
//  HAZ_DEPTH 3   issued-Rd history window; must equal pipe depth to write-back (>=1)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  rst        in   1   asynchronous, active-low reset
//  go         in   1   start/restart execution at PC=0 (sampled in IDLE/HALTED)
//  stall      in   1   external hold: issue bubble, no fetch, PC frozen
//  imem_rd    out  1   instruction read strobe (combinational)
//  imem_addr  out  AW  read address = pc
//  imem_data  in   32  read data, valid the cycle after imem_rd; memory holds it while imem_rd=0
//  opcode     out  3   to pipe: 000 NOP, 001 ADD, 010 MUL, 011 ADDI (registered)
//  Rs1,Rs2,Rd out  5   to pipe: register specifiers (registered)
//  imm        out  12  to pipe: signed immediate (registered)
//  start      out  1   1 = real instruction on outputs this cycle, 0 = bubble
//  pc         out  AW  current fetch address
//  halted     out  1   1 in HALTED state
// BEHAVIOUR
//  Word format: [31:20] imm, [19:15] Rs1, [14:10] Rs2, [9:5] Rd, [4:3] ignored, [2:0] op.
//  op 111 = HALT. op 100..110 are issued as a NOP bubble and do not enter the window.
//  Reset (rst=0, async): state IDLE, pc=0, v=0, window cleared.
//   Outputs opcode/Rs1/Rs2/Rd/imm=0, start=0, halted=0.
//  States:
//   IDLE   -> RUN on go=1 (pc<=0, v<=0).
//   RUN    -> HALTED when a valid HALT word is decoded and hold=0.
//   HALTED -> RUN on go=1 (pc<=0, v<=0, window cleared). go is ignored in RUN.
//  v = decode-valid flag.
//   Set at an edge where imem_rd=1.
//   Kept while the word is held.
//   Cleared when the word is consumed and no new read was issued.
//  Source regs read by a word: ADDI -> Rs1; ADD/MUL -> Rs1,Rs2; others -> none.
//  hazard = v & (a read source !=0 matches a nonzero Rd in the HAZ_DEPTH window).
//  hold = stall | hazard.
//  imem_rd = RUN & ~hold & ~(v & op==HALT). pc <= pc+1 (mod 2^AW) whenever imem_rd=1.
//  Issue (each edge in RUN):
//   - v & ~hold & op in {ADD,MUL,ADDI}: fields registered to outputs, start=1, word consumed.
//   - Otherwise a bubble is registered: all fields 0, start=0. A held word is not consumed.
//  Window shifts every edge in RUN. It takes issued Rd, or 0 on a bubble/NOP.
//   It is not shifted in IDLE/HALTED.
//  Latency: the edge sampling go is E0; word 0 appears on outputs after E2.
//   Steady throughput is 1 word/cycle with no hazards.
//  Stall and hazard in the same cycle: a single bubble; no word is lost or duplicated.
//  HALT word is not issued; outputs become a bubble and stay 0 in HALTED.
//   pc = HALT address + 1.
//  Outputs in IDLE/HALTED: bubble (all 0, start=0), imem_rd=0.
// TESTING
//  1 Mem {ADDI r1,r0,5; ADDI r2,r0,7; HALT}, go pulse
//    -> after E2 start=1 op=011 Rd=1 imm=5; next cycle Rd=2 imm=7;
//    -> then bubble, halted=1, pc=3.
//  2 HAZ_DEPTH=3, {ADDI r1,r0,5; ADD r3,r1,r1; HALT}
//    -> ADDI, then 3 bubbles (start=0), then ADD Rs1=Rs2=1 Rd=3.
//  3 10-word ADDI stream to distinct Rd, stall=1 for 2 cycles mid-stream
//    -> exactly 2 bubbles, imem_rd=0 and pc frozen during stall, all 10 Rd issued in order.
//  4 AW=4, 16 NOP words with no HALT
//    -> pc wraps 15->0, outputs stay bubbles, no X.
//  5 Word op=101 between two ADDIs
//    -> issued as bubble (start=0), no hazard window entry, next ADDI issued next cycle.
//  6 rst=0 asserted mid-stream at arbitrary phase
//    -> all outputs 0 immediately, IDLE; go restarts at pc=0 with correct sequence.

Source files
------------

// File: rtl/if_issue.sv
// Instruction fetch/issue front end: walks PC through a synchronous instruction memory,
// decodes each word and issues it to the pipe, inserting bubbles on RAW hazards or stall.
module if_issue #(
    parameter int unsigned AW        = 8,
    parameter int unsigned HAZ_DEPTH = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_go,
    input  logic          i_stall,
    output logic          o_imem_rd,
    output logic [AW-1:0] o_imem_addr,
    input  logic [31:0]   i_imem_data,
    output logic [2:0]    o_opcode,
    output logic [4:0]    o_rs1,
    output logic [4:0]    o_rs2,
    output logic [4:0]    o_rd,
    output logic [11:0]   o_imm,
    output logic          o_start,
    output logic [AW-1:0] o_pc,
    output logic          o_halted
);

    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpMul  = 3'b010;
    localparam logic [2:0] OpAddi = 3'b011;
    localparam logic [2:0] OpHalt = 3'b111;

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    state_e                      r_state, w_state_d;
    logic [AW-1:0]               r_pc, w_pc_d;
    logic                        r_v, w_v_d;
    logic [HAZ_DEPTH-1:0][4:0]   r_win, w_win_d;
    logic [2:0]                  r_opcode;
    logic [4:0]                  r_rs1, r_rs2, r_rd;
    logic [11:0]                 r_imm;
    logic                        r_start;

    logic [2:0]  w_op;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [11:0] w_imm;
    logic        w_use_rs1, w_use_rs2, w_match;
    logic        w_run, w_hazard, w_hold, w_is_halt, w_rd_en, w_issue;
    logic        w_unused;

    assign w_imm    = i_imem_data[31:20];
    assign w_rs1    = i_imem_data[19:15];
    assign w_rs2    = i_imem_data[14:10];
    assign w_rd     = i_imem_data[9:5];
    assign w_op     = i_imem_data[2:0];
    assign w_unused = ^i_imem_data[4:3];

    // Only ADD/MUL/ADDI are real instructions; they are exactly the words reading Rs1.
    assign w_use_rs1 = (w_op == OpAdd) || (w_op == OpMul) || (w_op == OpAddi);
    assign w_use_rs2 = (w_op == OpAdd) || (w_op == OpMul);

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
            if (r_win[i] != 5'd0 &&
                ((w_use_rs1 && r_win[i] == w_rs1) || (w_use_rs2 && r_win[i] == w_rs2))) begin
                w_match = 1'b1;
            end
        end
    end

    assign w_run     = (r_state == StRun);
    assign w_hazard  = r_v & w_match;
    assign w_hold    = i_stall | w_hazard;
    assign w_is_halt = r_v & (w_op == OpHalt);
    assign w_rd_en   = w_run & ~w_hold & ~w_is_halt;
    assign w_issue   = w_run & r_v & ~w_hold & w_use_rs1;

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_v_d     = r_v;
        w_win_d   = r_win;
        unique case (r_state)
            StIdle, StHalted: begin
                if (i_go) begin
                    w_state_d = StRun;
                    w_pc_d    = '0;
                    w_v_d     = 1'b0;
                    w_win_d   = '0;
                end
            end
            StRun: begin
                if (w_rd_en) begin
                    w_pc_d = r_pc + 1'b1;
                    w_v_d  = 1'b1;
                end else if (r_v && !w_hold) begin
                    w_v_d = 1'b0;
                end
                w_win_d[0] = w_issue ? w_rd : 5'd0;
                for (int i = 1; i < int'(HAZ_DEPTH); i++) begin
                    w_win_d[i] = r_win[i-1];
                end
                if (w_is_halt && !w_hold) begin
                    w_state_d = StHalted;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_pc     <= '0;
            r_v      <= 1'b0;
            r_win    <= '0;
            r_opcode <= 3'd0;
            r_rs1    <= 5'd0;
            r_rs2    <= 5'd0;
            r_rd     <= 5'd0;
            r_imm    <= 12'd0;
            r_start  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_pc     <= w_pc_d;
            r_v      <= w_v_d;
            r_win    <= w_win_d;
            r_opcode <= w_issue ? w_op  : 3'd0;
            r_rs1    <= w_issue ? w_rs1 : 5'd0;
            r_rs2    <= w_issue ? w_rs2 : 5'd0;
            r_rd     <= w_issue ? w_rd  : 5'd0;
            r_imm    <= w_issue ? w_imm : 12'd0;
            r_start  <= w_issue;
        end
    end

    assign o_imem_rd   = w_rd_en;
    assign o_imem_addr = r_pc;
    assign o_pc        = r_pc;
    assign o_opcode    = r_opcode;
    assign o_rs1       = r_rs1;
    assign o_rs2       = r_rs2;
    assign o_rd        = r_rd;
    assign o_imm       = r_imm;
    assign o_start     = r_start;
    assign o_halted    = (r_state == StHalted);

endmodule

// File: tb/tb_if_issue.sv
// Bench for if_issue: directed programs plus random programs/stalls, every cycle checked
// against an instruction-level reference model of the fetch/issue front end.
module tb_if_issue;

    localparam int HD = 3;

    logic        clk = 1'b0;
    logic        rst_n, go, stall;
    logic        o_imem_rd, o_start, o_halted;
    logic [7:0]  o_imem_addr, o_pc;
    logic [31:0] imem_q = '0;
    logic [2:0]  o_opcode;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [11:0] o_imm;

    logic [31:0] mem [256];
    int checks = 0;
    int failures = 0;

    // Per-cycle trace of one run, index 0 = cycle right after the edge that samples go.
    int lg_start [512];
    int lg_op    [512];
    int lg_rs1   [512];
    int lg_rs2   [512];
    int lg_rd    [512];
    int lg_imm   [512];
    int lg_pc    [512];
    int lg_rdstb [512];
    int lg_halt  [512];

    if_issue #(.AW(8), .HAZ_DEPTH(HD)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_go        (go),
        .i_stall     (stall),
        .o_imem_rd   (o_imem_rd),
        .o_imem_addr (o_imem_addr),
        .i_imem_data (imem_q),
        .o_opcode    (o_opcode),
        .o_rs1       (o_rs1),
        .o_rs2       (o_rs2),
        .o_rd        (o_rd),
        .o_imm       (o_imm),
        .o_start     (o_start),
        .o_pc        (o_pc),
        .o_halted    (o_halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_imem_rd) imem_q <= mem[o_imem_addr];
    end

    // Reference model: mode 0 idle, 1 run, 2 halted; one pending fetched word; Rd history.
    int          m_mode;
    logic [7:0]  m_pc;
    bit          m_have;
    logic [31:0] m_word;
    int          m_win [HD];
    int          e_start, e_op, e_rs1, e_rs2, e_rd, e_imm;

    function automatic bit m_hazard();
        int op = int'(m_word[2:0]);
        int s1 = int'(m_word[19:15]);
        int s2 = int'(m_word[14:10]);
        bit r1 = (op == 1 || op == 2 || op == 3);
        bit r2 = (op == 1 || op == 2);
        if (!m_have) return 1'b0;
        for (int i = 0; i < HD; i++) begin
            if (m_win[i] != 0 && ((r1 && m_win[i] == s1) || (r2 && m_win[i] == s2))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_fetch();
        return m_mode == 1 && !(stall || m_hazard()) && !(m_have && m_word[2:0] == 3'd7);
    endfunction

    always @(posedge clk or negedge rst_n) begin : ref_model
        int op;
        bit hold, issue, fetch;
        int nw [HD];
        if (!rst_n) begin
            m_mode <= 0; m_pc <= 8'd0; m_have <= 1'b0; m_word <= '0;
            for (int i = 0; i < HD; i++) m_win[i] <= 0;
            e_start <= 0; e_op <= 0; e_rs1 <= 0; e_rs2 <= 0; e_rd <= 0; e_imm <= 0;
        end else begin
            op    = int'(m_word[2:0]);
            hold  = stall || m_hazard();
            fetch = m_fetch();
            if (m_mode != 1) begin
                e_start <= 0; e_op <= 0; e_rs1 <= 0; e_rs2 <= 0; e_rd <= 0; e_imm <= 0;
                if (go) begin
                    m_mode <= 1; m_pc <= 8'd0; m_have <= 1'b0;
                    for (int i = 0; i < HD; i++) m_win[i] <= 0;
                end
            end else begin
                issue = m_have && !hold && (op == 1 || op == 2 || op == 3);
                e_start <= issue ? 1 : 0;
                e_op    <= issue ? op : 0;
                e_rs1   <= issue ? int'(m_word[19:15]) : 0;
                e_rs2   <= issue ? int'(m_word[14:10]) : 0;
                e_rd    <= issue ? int'(m_word[9:5]) : 0;
                e_imm   <= issue ? int'(m_word[31:20]) : 0;
                nw[0] = issue ? int'(m_word[9:5]) : 0;
                for (int i = 1; i < HD; i++) nw[i] = m_win[i-1];
                m_win <= nw;
                if (m_have && !hold && op == 7) m_mode <= 2;
                if (fetch) begin
                    m_word <= mem[m_pc];
                    m_pc   <= m_pc + 8'd1;
                end
                m_have <= fetch || (m_have && hold);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit bad;
        int exp_rdstb;
        exp_rdstb = m_fetch() ? 1 : 0;
        bad = $isunknown({o_start, o_opcode, o_rs1, o_rs2, o_rd, o_imm, o_pc, o_imem_rd,
                          o_imem_addr, o_halted})
            || int'(o_start) != e_start || int'(o_opcode) != e_op || int'(o_rs1) != e_rs1
            || int'(o_rs2) != e_rs2 || int'(o_rd) != e_rd || int'(o_imm) != e_imm
            || o_pc != m_pc || o_imem_addr != m_pc || int'(o_imem_rd) != exp_rdstb
            || o_halted != (m_mode == 2);
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL cycle_compare t=%0t got start=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%0d pc=%0d rd_stb=%0d halted=%0d want start=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%0d pc=%0d rd_stb=%0d halted=%0d",
                     $time, o_start, o_opcode, o_rs1, o_rs2, o_rd, o_imm, o_pc, o_imem_rd,
                     o_halted, e_start, e_op, e_rs1, e_rs2, e_rd, e_imm, m_pc, exp_rdstb,
                     (m_mode == 2));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2,
                                        input int imm);
        logic [31:0] w;
        w = {12'(imm), 5'(rs1), 5'(rs2), 5'(rd), 2'b00, 3'(op)};
        return w;
    endfunction

    function automatic bit pick_stall(input int n, input int from, input int len, input bit rnd);
        if (rnd) return $urandom_range(0, 3) == 0;
        return n >= from && n < from + len;
    endfunction

    task automatic run(input int budget, input int st_from, input int st_len, input bit rnd,
                       input bit expect_halt, input string nm);
        int n = 0;
        bit done = 1'b0;
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
        stall = pick_stall(0, st_from, st_len, rnd);
        while (n < budget && !done) begin
            @(negedge clk);
            lg_start[n] = int'(o_start); lg_op[n] = int'(o_opcode); lg_rs1[n] = int'(o_rs1);
            lg_rs2[n] = int'(o_rs2); lg_rd[n] = int'(o_rd); lg_imm[n] = int'(o_imm);
            lg_pc[n] = int'(o_pc); lg_rdstb[n] = int'(o_imem_rd); lg_halt[n] = int'(o_halted);
            if (o_halted) done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
                n++;
                stall = pick_stall(n, st_from, st_len, rnd);
            end
        end
        stall = 1'b0;
        if (expect_halt) chk({nm, "_halt_reached"}, int'(done), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cnt, ok, first, last, len, r;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0; go = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_start", int'(o_start), 0);
        chk("reset_pc", int'(o_pc), 0);
        chk("reset_halted", int'(o_halted), 0);
        chk("reset_imem_rd", int'(o_imem_rd), 0);

        // Two ADDIs then HALT
        mem[0] = enc(3, 1, 0, 0, 5); mem[1] = enc(3, 2, 0, 0, 7); mem[2] = enc(7, 0, 0, 0, 0);
        run(40, -1, 0, 1'b0, 1'b1, "t1");
        chk("t1_start2", lg_start[2], 1); chk("t1_op2", lg_op[2], 3);
        chk("t1_rd2", lg_rd[2], 1);       chk("t1_imm2", lg_imm[2], 5);
        chk("t1_rd3", lg_rd[3], 2);       chk("t1_imm3", lg_imm[3], 7);
        chk("t1_bubble4", lg_start[4], 0); chk("t1_halt4", lg_halt[4], 1);
        chk("t1_pc4", lg_pc[4], 3);

        // RAW hazard: ADD waits HAZ_DEPTH bubbles for r1
        mem[0] = enc(3, 1, 0, 0, 5); mem[1] = enc(1, 3, 1, 1, 0); mem[2] = enc(7, 0, 0, 0, 0);
        run(40, -1, 0, 1'b0, 1'b1, "t2");
        chk("t2_addi", lg_start[2], 1);
        chk("t2_bub3", lg_start[3], 0); chk("t2_bub4", lg_start[4], 0);
        chk("t2_bub5", lg_start[5], 0);
        chk("t2_add_start", lg_start[6], 1); chk("t2_add_op", lg_op[6], 1);
        chk("t2_add_rs1", lg_rs1[6], 1); chk("t2_add_rs2", lg_rs2[6], 1);
        chk("t2_add_rd", lg_rd[6], 3);

        // 10 independent ADDIs, 2-cycle stall mid-stream
        for (int i = 0; i < 10; i++) mem[i] = enc(3, i + 1, 0, 0, i * 3);
        mem[10] = enc(7, 0, 0, 0, 0);
        run(60, 5, 2, 1'b0, 1'b1, "t3");
        cnt = 0; ok = 1; first = -1; last = -1;
        for (int i = 0; i < 60; i++) begin
            if (lg_start[i] == 1) begin
                if (lg_rd[i] != cnt + 1) ok = 0;
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
            if (lg_halt[i] == 1) break;
        end
        chk("t3_issued", cnt, 10); chk("t3_in_order", ok, 1);
        chk("t3_first", first, 2); chk("t3_last", last, 13);
        chk("t3_rdstb5", lg_rdstb[5], 0); chk("t3_rdstb6", lg_rdstb[6], 0);
        chk("t3_pc5", lg_pc[5], 5); chk("t3_pc6", lg_pc[6], 5); chk("t3_pc7", lg_pc[7], 5);

        // Reserved op between ADDIs: bubble, no window entry for its Rd field
        mem[0] = enc(3, 1, 0, 0, 4); mem[1] = enc(5, 2, 1, 1, 0);
        mem[2] = enc(3, 3, 2, 0, 9); mem[3] = enc(7, 0, 0, 0, 0);
        run(40, -1, 0, 1'b0, 1'b1, "t5");
        chk("t5_addi1", lg_rd[2], 1); chk("t5_rsv_start", lg_start[3], 0);
        chk("t5_rsv_op", lg_op[3], 0); chk("t5_addi2_start", lg_start[4], 1);
        chk("t5_addi2_rd", lg_rd[4], 3); chk("t5_addi2_rs1", lg_rs1[4], 2);
        chk("t5_addi2_imm", lg_imm[4], 9);

        // Random programs with hazards, reserved ops and random stalls
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(4, 20);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                mem[i] = enc(r < 3 ? 3 : r < 5 ? 1 : r < 6 ? 2 : r < 7 ? 0 : $urandom_range(4, 6),
                             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                             $urandom_range(0, 4095));
            end
            mem[len] = enc(7, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
            run(400, -1, 0, it % 2 == 1, 1'b1, "rnd");
        end

        // All-NOP memory, no HALT: pc wraps, outputs stay bubbles
        for (int i = 0; i < 256; i++) mem[i] = '0;
        run(262, -1, 0, 1'b0, 1'b0, "t4");
        chk("t4_pc255", lg_pc[255], 255); chk("t4_pc256", lg_pc[256], 0);
        chk("t4_pc257", lg_pc[257], 1);
        ok = 1;
        for (int i = 0; i < 262; i++) if (lg_start[i] != 0) ok = 0;
        chk("t4_all_bubbles", ok, 1);

        // Async reset mid-cycle while running, then restart
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("t6_start", int'(o_start), 0); chk("t6_pc", int'(o_pc), 0);
        chk("t6_imem_rd", int'(o_imem_rd), 0); chk("t6_halted", int'(o_halted), 0);
        repeat (2) @(posedge clk);
        mem[0] = enc(3, 1, 0, 0, 5); mem[1] = enc(3, 2, 0, 0, 7); mem[2] = enc(7, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        run(40, -1, 0, 1'b0, 1'b1, "t6");
        chk("t6_rd2", lg_rd[2], 1); chk("t6_rd3", lg_rd[3], 2); chk("t6_halt4", lg_halt[4], 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
